// File: rtl/lfsr_stream_gen.sv
// Runtime-configurable Fibonacci/Galois LFSR with STEP shifts per transfer, streamed over valid/ready.
// Optional sequence-period measurement is built when LFSR_PERIOD_CNT_EN is defined.
module lfsr_stream_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int STEP       = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cfg_load,
   input  logic [DATA_WIDTH-1:0] cfg_seed,
   input  logic [DATA_WIDTH-1:0] cfg_taps,
   input  logic                  cfg_mode,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  lockup_err,
   output logic [DATA_WIDTH-1:0] period,
   output logic                  period_done
);

   // Stream handshake: a word is transferred on every edge where out_valid && out_ready;
   // out_valid never depends on out_ready and stays high for as long as the FSM is in RUN.

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] lfsr_q;
   logic [DATA_WIDTH-1:0] taps_q;
   logic                  mode_q;
   logic                  valid_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] adv;
   logic [DATA_WIDTH-1:0] adv_fixed;
   logic [DATA_WIDTH-1:0] load_val;
   logic                  xfer;

   function automatic logic [DATA_WIDTH-1:0] shift_once(
      input logic [DATA_WIDTH-1:0] s,
      input logic [DATA_WIDTH-1:0] t,
      input logic                  galois
   );
      if (galois)
         shift_once = {1'b0, s[DATA_WIDTH-1:1]} ^ ({DATA_WIDTH{s[0]}} & t);
      else
         shift_once = {^(s & t), s[DATA_WIDTH-1:1]};
   endfunction

   // STEP single shifts chained in one cycle; only the final word is checked for lock-up.
   always_comb begin
      adv = lfsr_q;
      for (int i = 0; i < STEP; i++)
         adv = shift_once(adv, taps_q, mode_q);
   end

   assign adv_fixed = (adv == '0) ? ONE : adv;
   assign load_val  = (cfg_seed == '0) ? ONE : cfg_seed;
   assign xfer      = valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         lfsr_q  <= ONE;
         taps_q  <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (cfg_load) begin
         state_q <= RUN;
         valid_q <= 1'b1;
         lfsr_q  <= load_val;
         taps_q  <= cfg_taps;
         mode_q  <= cfg_mode;
         err_q   <= (cfg_seed == '0);
      end else begin
         case (state_q)
            IDLE: valid_q <= 1'b0;
            RUN: begin
               valid_q <= 1'b1;
               if (xfer) begin
                  lfsr_q <= adv_fixed;
                  if (adv == '0)
                     err_q <= 1'b1;
               end
            end
            default: valid_q <= 1'b0;
         endcase
      end
   end

   assign out_valid  = valid_q;
   assign dout       = lfsr_q;
   assign lockup_err = err_q;

`ifdef LFSR_PERIOD_CNT_EN
   logic [DATA_WIDTH-1:0] seed_q;
   logic [DATA_WIDTH-1:0] cnt_q;
   logic [DATA_WIDTH-1:0] period_q;
   logic                  done_q;

   // A saturated counter means the sequence never returned to its seed; stop reporting.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         seed_q   <= ONE;
         cnt_q    <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
      end else if (cfg_load) begin
         seed_q <= load_val;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (xfer) begin
         if (cnt_q == '1) begin
            done_q <= 1'b0;
         end else if (adv_fixed == seed_q) begin
            period_q <= cnt_q + ONE;
            done_q   <= 1'b1;
            cnt_q    <= '0;
         end else begin
            cnt_q  <= cnt_q + ONE;
            done_q <= 1'b0;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign period      = period_q;
   assign period_done = done_q;
`else
   assign period      = '0;
   assign period_done = 1'b0;
`endif

endmodule

// File: doc/lfsr_stream_gen.md
# lfsr_stream_gen

Parametrised pseudo-random stream generator that replaces the single-mode, one-bit-per-clock LFSR with a runtime-configurable engine. It supports Fibonacci or Galois feedback and advances STEP bits per accepted transfer. Results are delivered over a valid/ready output stream, and an all-zero lock-up state is detected and repaired. It sits between the test-pattern/scrambler control logic and any stream consumer that needs back-pressurable pseudo-random words.

## Interface
- DATA_WIDTH, 16, LFSR state and output width (≥ 2)
- STEP, 1, LFSR shifts applied per accepted transfer (1..DATA_WIDTH)
- clk  input  1  rising-edge clock
- resetn  input  1  reset; synchronous, active-low
- cfg_load  input  1  single-cycle pulse; registers cfg_seed, cfg_taps, cfg_mode
- cfg_seed  input  DATA_WIDTH  initial state
- cfg_taps  input  DATA_WIDTH  feedback polynomial mask
- cfg_mode  input  1  0 = Fibonacci, 1 = Galois
- out_ready  input  1  consumer accepts dout this cycle
- out_valid  output  1  dout holds a valid word
- dout  output  DATA_WIDTH  current LFSR state
- lockup_err  output  1  sticky; a zero state was replaced
- period  output  DATA_WIDTH  last measured sequence length, in transfers (macro only)
- period_done  output  1  one-cycle pulse when period updates (macro only)

## Operation
- FSM with two states, IDLE and RUN.
  - Reset → IDLE.
  - cfg_load in any state → RUN.
  - No other transitions.
- Reset values:
  - dout = 1
  - out_valid = 0
  - lockup_err = 0
  - taps register = 0
  - mode = Fibonacci
  - period = 0
  - period_done = 0
- Load:
  - On cfg_load, the state becomes cfg_seed, and taps and mode are registered.
  - If cfg_seed == 0, the state becomes 1 and lockup_err is set.
  - Otherwise lockup_err is cleared.
- Single-shift rules (s = state, t = taps):
  - Fibonacci: fb = ^(s & t); s' = {fb, s[W-1:1]}.
  - Galois: s' = {1'b0, s[W-1:1]} ^ ({W{s[0]}} & t).
- Advance:
  - A transfer occurs when out_valid && out_ready.
  - The state takes STEP single shifts, chained combinationally in one cycle.
- Lock-up:
  - If an advance would produce 0, the state is loaded with 1 instead.
  - lockup_err is set and stays set until the next cfg_load or reset.
- Priority:
  - resetn has highest priority, then cfg_load, then the advance.
  - A cfg_load coinciding with a transfer discards that advance. The word on dout that cycle still counts as accepted.
- out_valid stays 1 in RUN. The stream never stalls on the producer side.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- dout updates on the clock edge after an accepted transfer: 1-cycle latency, one word per cycle at full throughput.
- With out_ready low, dout holds indefinitely.
- After cfg_load at edge N, dout = seed (or 1) and out_valid = 1 from edge N.
- Reset mid-stream: out_valid falls at the next edge and dout returns to 1.

## Configuration
- Macro: LFSR_PERIOD_CNT_EN.
- Defined:
  - A DATA_WIDTH-bit counter increments on each transfer. It is cleared by cfg_load and by reset.
  - When a post-advance state equals the loaded (possibly zero-repaired) seed:
    - period ← counter + 1
    - period_done pulses for one cycle
    - the counter clears
  - The counter saturates at all-ones, and no period_done fires while saturated.
- Undefined: the counter logic is absent; period and period_done are tied to 0.

## Test plan
- Reset hold: reset for 3 cycles → out_valid = 0, dout = 0x0001, lockup_err = 0; stays in IDLE with out_ready = 1.
- Fibonacci, W = 8, STEP = 1: cfg_load seed 0x01, taps 0x01, mode 0, out_ready = 1 → dout sequence 0x01, 0x80, 0x40, 0x20 …. With the macro defined, period_done fires after 8 transfers with period = 8.
- Galois, W = 8: seed 0x01, taps 0xB8, mode 1 → 0x01, 0xB8, 0x5C, 0x2E. With the macro defined, period = 255.
- STEP = 2, Fibonacci, W = 8: seed 0x01, taps 0x01 → 0x01, 0x40, 0x10.
  - Drop out_ready for 4 cycles mid-stream → dout frozen throughout, no word skipped.
- Lock-up:
  - seed 0x00 → dout = 0x01, lockup_err = 1.
  - Fibonacci with taps 0x00 from seed 0x01 → the advance yields 1 again and lockup_err stays 1.
  - A new cfg_load with seed 0x05 clears lockup_err.
- Collision: cfg_load coinciding with a transfer → next dout = new seed (not the advanced value). Reset asserted mid-RUN → out_valid = 0 next cycle.
